// File: rtl/barrett_pkg.sv
// Shared types and constants for the Barrett multiplier sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package barrett_pkg;

    localparam int N_DEF = 8;            // default operand width
    localparam int M_DEF = 4;            // default digit width
    localparam int D     = N_DEF / M_DEF; // digits per operand at the defaults

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        CAPTURE,
        CORRECT,
        DONE
    } state_t;

    // Width of the Barrett constant mu for a given digit width.
    function automatic int mu_width(input int digit_w);
        return digit_w + 5;
    endfunction

endpackage

// File: rtl/barrett_digit_sr.sv
// n-bit operand register that loads in parallel and shifts left one digit at a time.
// Latency: load or shift visible one cycle after the enabling edge.
// Backpressure: none; load has priority over shift.
module barrett_digit_sr #(
    parameter int n = 8,
    parameter int m = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [n-1:0] load_dat_i,
    input  logic         shift_i,
    output logic [m-1:0] top_o
);

    logic [n-1:0] sr_q;

    // Parallel load of B, then MSB-first digit shifting.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_dat_i;
        end else if (shift_i) begin
            sr_q <= sr_q << m;
        end
    end

    assign top_o = sr_q[n-1 -: m];

endmodule

// File: rtl/barrett_seq_ctrl.sv
// Word-level valid/ready front end that sequences the digit-serial Barrett core (BARRETT_FINAL_SUB_EN adds a final conditional subtract).
// Latency: accept to OUT_VALID is n/m+3 cycles, n/m+4 with BARRETT_FINAL_SUB_EN.
// Backpressure: result held in DONE until OUT_READY; IN_READY only high in IDLE, no input queuing.
module barrett_seq_ctrl
    import barrett_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int m = M_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [n-1:0]             A,
    input  logic [n-1:0]             B,
    input  logic [n-1:0]             M_IN,
    input  logic [mu_width(m)-1:0]   MU_IN,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [n:0]               Z,
    output logic                     CORE_RST,
    output logic                     CARRY_ADD,
    output logic                     CARRY_SUB,
    output logic [n-1:0]             X,
    output logic [m-1:0]             Y_i,
    output logic [n-1:0]             M,
    output logic [mu_width(m)-1:0]   mu,
    input  logic [n:0]               Z_OUT
);

    localparam int DL  = n / m;
    localparam int KW  = $clog2(DL + 1);
    localparam int MUW = mu_width(m);

    if (n % m != 0) begin : g_bad_width
        $error("barrett_seq_ctrl: operand width n must be a multiple of digit width m");
    end

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            core_rst_q;
    logic [m-1:0]    y_q;
    logic [n:0]      z_q;
    logic [n-1:0]    x_q;
    logic [n-1:0]    m_q;
    logic [MUW-1:0]  mu_q;
    logic [m-1:0]    sr_top;
    logic            accept;
    logic            last_digit;
    logic            sr_shift;

    assign accept     = IN_VALID && in_ready_q;
    assign last_digit = (k_q == KW'(DL));
    assign sr_shift   = (state_q == FEED) && !last_digit;

    barrett_digit_sr #(
        .n (n),
        .m (m)
    ) u_digit_sr (
        .clk_i      (CLK),
        .rst_n_i    (RST),
        .load_i     (accept),
        .load_dat_i (B),
        .shift_i    (sr_shift),
        .top_o      (sr_top)
    );

    // Operation sequencer; every core-facing and host-facing output is registered here.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            core_rst_q  <= 1'b0;
            y_q         <= '0;
            z_q         <= '0;
            x_q         <= '0;
            m_q         <= '0;
            mu_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    core_rst_q <= 1'b1;
                    if (accept) begin
                        state_q    <= CLEAR;
                        in_ready_q <= 1'b0;
                        core_rst_q <= 1'b0;
                        x_q        <= A;
                        m_q        <= M_IN;
                        mu_q       <= MU_IN;
                    end
                end
                CLEAR: begin
                    // Core leaves reset; first FEED cycle presents the leading zero digit.
                    state_q    <= FEED;
                    core_rst_q <= 1'b1;
                    k_q        <= '0;
                    y_q        <= '0;
                end
                FEED: begin
                    if (last_digit) begin
                        state_q <= CAPTURE;
                        y_q     <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                        y_q <= sr_top;
                    end
                end
                CAPTURE: begin
                    z_q <= Z_OUT;
`ifdef BARRETT_FINAL_SUB_EN
                    state_q <= CORRECT;
`else
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
`endif
                end
`ifdef BARRETT_FINAL_SUB_EN
                CORRECT: begin
                    // One conditional subtraction brings the core result below M.
                    if (z_q >= {1'b0, m_q}) begin
                        z_q <= z_q - {1'b0, m_q};
                    end
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
`endif
                DONE: begin
                    if (OUT_READY) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    core_rst_q  <= 1'b1;
                    y_q         <= '0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign Z         = z_q;
    assign CORE_RST  = core_rst_q;
    assign CARRY_ADD = 1'b0;
    assign CARRY_SUB = 1'b1;
    assign X         = x_q;
    assign Y_i       = y_q;
    assign M         = m_q;
    assign mu        = mu_q;

endmodule

// File: tb/tb_barrett_seq_ctrl.sv
// Self-checking bench for barrett_seq_ctrl with a behavioural core stub.
// The stub rebuilds B from the streamed digits and returns (X*B) mod M, or M+5 when forced.
// Expected values come from plain modular arithmetic and the digit order rule.
module tb_barrett_seq_ctrl;

    localparam int N   = 8;
    localparam int MW  = 4;
    localparam int DG  = N / MW;
    localparam int MUW = MW + 5;
`ifdef BARRETT_FINAL_SUB_EN
    localparam int LAT  = DG + 4;
    localparam bit FSUB = 1'b1;
`else
    localparam int LAT  = DG + 3;
    localparam bit FSUB = 1'b0;
`endif
    localparam int IVL = LAT + 2;
    localparam int NV  = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic           IN_VALID;
    logic           IN_READY;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [N-1:0]   M_IN;
    logic [MUW-1:0] MU_IN;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [N:0]     Z;
    logic           CORE_RST;
    logic           CARRY_ADD;
    logic           CARRY_SUB;
    logic [N-1:0]   X;
    logic [MW-1:0]  Y_i;
    logic [N-1:0]   M;
    logic [MUW-1:0] mu;
    logic [N:0]     Z_OUT;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int got_q[$];

    bit          stub_force = 1'b0;
    logic [31:0] acc;

    barrett_seq_ctrl #(.n(N), .m(MW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .M_IN      (M_IN),
        .MU_IN     (MU_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Z         (Z),
        .CORE_RST  (CORE_RST),
        .CARRY_ADD (CARRY_ADD),
        .CARRY_SUB (CARRY_SUB),
        .X         (X),
        .Y_i       (Y_i),
        .M         (M),
        .mu        (mu),
        .Z_OUT     (Z_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Core stub: accumulates digits since its last reset, MSB first.
    always @(posedge CLK) begin
        if (!CORE_RST) acc <= '0;
        else           acc <= (acc << MW) | 32'(Y_i);
    end

    always_comb begin
        if (stub_force)     Z_OUT = {1'b0, M} + 9'd5;
        else if (M == '0)   Z_OUT = '0;
        else                Z_OUT = 9'((longint'(X) * longint'(acc)) % longint'(M));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_c();
        tick();
        if (OUT_VALID === 1'b1) got_q.push_back(int'(Z));
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Digit expected on Y_i e cycles after the accept edge: zero in CLEAR and FEED k=0,
    // then B's digits MSB first, zero afterwards.
    function automatic int exp_digit(input int b, input int e);
        if (e >= 2 && e <= DG + 1) return (b >> ((DG - (e - 1)) * MW)) & ((1 << MW) - 1);
        return 0;
    endfunction

    task automatic do_op(input int a, input int b, input int mm, input int mu_v,
                         output int lat, output int z, output int rst_low, output int seq_err);
        int guard;
        guard = 0;
        while (IN_READY !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        A = N'(a); B = N'(b); M_IN = N'(mm); MU_IN = MUW'(mu_v);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        A = N'($urandom); B = N'($urandom); M_IN = N'($urandom); MU_IN = MUW'($urandom);
        lat = 0; rst_low = 0; seq_err = 0;
        while (OUT_VALID !== 1'b1 && lat < 30) begin
            if (CORE_RST !== 1'b1) rst_low++;
            if (int'(Y_i) != exp_digit(b, lat)) seq_err++;
            tick();
            lat++;
        end
        z = int'(Z);
    endtask

    initial begin
        int lat, z, rl, se, bad, z0, mu0, guard;
        int va[NV], vb[NV], vm[NV], vg[NV], acc_cyc[NV];
        int ra, rb, rm;

        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A = '0; B = '0; M_IN = '0; MU_IN = '0;
        mu0 = (1 << (N + MW + 3)) / 251;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_z", Z, 0);
        chk("rst_core_rst", CORE_RST, 0);
        chk("rst_y", Y_i, 0);
        chk("rst_x", X, 0);
        chk("rst_m", M, 0);
        chk("rst_mu", mu, 0);
        chk("carry_add", CARRY_ADD, 0);
        chk("carry_sub", CARRY_SUB, 1);

        RST = 1'b1;
        tick();
        chk("post_rst_in_ready", IN_READY, 1);
        chk("post_rst_core_rst", CORE_RST, 1);
        repeat (3) tick();
        chk("post_rst_no_valid", OUT_VALID, 0);

        // Basic operation with the reference operands.
        do_op(200, 150, 251, mu0, lat, z, rl, se);
        chk("basic_latency", lat, LAT);
        chk("basic_z", z, (200 * 150) % 251);
        chk("basic_core_rst_low_cycles", rl, 1);
        chk("basic_digit_seq_errors", se, 0);
        chk("basic_x_held", X, 200);
        chk("basic_m_held", M, 251);
        chk("basic_mu_held", mu, mu0);
        chk("basic_in_ready_low", IN_READY, 0);

        // Backpressure: result must stay put for ten cycles.
        z0 = int'(Z);
        bad = 0;
        repeat (10) begin
            tick();
            if (int'(Z) != z0 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) bad++;
        end
        chk("backpressure_hold_violations", bad, 0);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("release_in_ready", IN_READY, 1);
        chk("release_out_valid", OUT_VALID, 0);

        // Randomized single operations, each released immediately.
        repeat (4) begin
            rm = $urandom_range(2, 255);
            ra = $urandom_range(0, rm - 1);
            rb = $urandom_range(0, 255);
            do_op(ra, rb, rm, mu0, lat, z, rl, se);
            chk("rand_latency", lat, LAT);
            chk("rand_z", z, (ra * rb) % rm);
            chk("rand_digit_seq_errors", se, 0);
            OUT_READY = 1'b1;
            tick();
            OUT_READY = 1'b0;
        end

        // Back-to-back vectors with IN_VALID and OUT_READY held high.
        for (int i = 0; i < NV; i++) begin
            vm[i] = $urandom_range(2, 255);
            va[i] = $urandom_range(0, vm[i] - 1);
            vb[i] = $urandom_range(0, vm[i] - 1);
            vg[i] = (va[i] * vb[i]) % vm[i];
        end
        got_q.delete();
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        for (int i = 0; i < NV; i++) begin
            A = N'(va[i]); B = N'(vb[i]); M_IN = N'(vm[i]); MU_IN = MUW'(mu0);
            guard = 0;
            while (IN_READY !== 1'b1 && guard < 40) begin
                tick_c();
                guard++;
            end
            tick_c();
            acc_cyc[i] = cyc;
            if (i == NV - 1) IN_VALID = 1'b0;
        end
        repeat (LAT + 3) tick_c();
        OUT_READY = 1'b0;
        chk("b2b_result_count", got_q.size(), NV);
        for (int i = 0; i < NV; i++) begin
            chk("b2b_z", (i < got_q.size()) ? got_q[i] : -1, vg[i]);
        end
        for (int i = 1; i < NV; i++) begin
            chk("b2b_accept_interval", acc_cyc[i] - acc_cyc[i - 1], IVL);
        end

        // Reset in FEED with the first real digit on Y_i.
        guard = 0;
        while (IN_READY !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        A = N'(77); B = N'(8'hA5); M_IN = N'(239); MU_IN = MUW'(mu0);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        chk("midfeed_first_digit", Y_i, 4'hA);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("midfeed_rst_out_valid", OUT_VALID, 0);
        chk("midfeed_rst_in_ready", IN_READY, 0);
        chk("midfeed_rst_core_rst", CORE_RST, 0);
        chk("midfeed_rst_y", Y_i, 0);
        chk("midfeed_rst_z", Z, 0);
        bad = 0;
        repeat (12) begin
            tick();
            if (OUT_VALID !== 1'b0) bad++;
        end
        chk("midfeed_no_result", bad, 0);
        chk("midfeed_idle_ready", IN_READY, 1);
        do_op(77, 165, 239, mu0, lat, z, rl, se);
        chk("after_abort_latency", lat, LAT);
        chk("after_abort_z", z, (77 * 165) % 239);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Core returning M+5: corrected to 5 only with the final subtraction.
        stub_force = 1'b1;
        do_op(120, 33, 251, mu0, lat, z, rl, se);
        chk("final_sub_latency", lat, LAT);
        chk("final_sub_z", z, FSUB ? 5 : 251 + 5);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        stub_force = 1'b0;
        chk("final_sub_release", IN_READY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrett_seq_ctrl.md
# barrett_seq_ctrl

Sequencer that drives the digit-serial Barrett modular multiplier core (`Barrett_4`) from a word-level valid/ready interface. Accepts full operands A, B, M and mu in one transfer, then pulses the core's reset. It streams the B digits MSB-first, preceded by one zero digit, over n/m+1 cycles, captures Z_OUT and presents the result with its own valid/ready handshake. Sits between the host or test harness and the core; it replaces per-cycle software sequencing of Y_i.

## Interface
- n, 8, operand width; must be a multiple of m.
- m, 4, digit width fed to core per cycle.
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  synchronous, active-low reset.
- IN_VALID  in  1  host offers an operand set.
- IN_READY  out  1  high only in IDLE.
- A  in  n  multiplicand.
- B  in  n  multiplier, consumed digit-serially.
- M_IN  in  n  modulus.
- MU_IN  in  m+5  Barrett constant for M_IN, host-computed.
- OUT_VALID  out  1  result held valid.
- OUT_READY  in  1  host accepts result.
- Z  out  n+1  registered result.
- CORE_RST  out  1  active-low reset to core.
- CARRY_ADD  out  1  constant 0.
- CARRY_SUB  out  1  constant 1.
- X  out  n  registered A to core.
- Y_i  out  m  current digit to core.
- M  out  n  registered modulus to core.
- mu  out  m+5  registered mu to core.
- Z_OUT  in  n+1  core result.

## Operation
- Constant D = n/m. Transfer accepted when IN_VALID && IN_READY. X, M, mu and the B shift register are loaded on that edge.
- States, with default flow and no stalls:
  - IDLE: on accept, go to CLEAR.
  - CLEAR: CORE_RST=0 and Y_i=0 for one cycle, then go to FEED.
  - FEED: lasts D+1 cycles with index k=0..D. At k=0, Y_i=0. At k≥1, Y_i = B[(D-k)*m +: m], so the MSB digit comes first. After k=D, go to CAPTURE.
  - CAPTURE: Z ← Z_OUT, then go to DONE.
  - DONE: OUT_VALID=1, with Z stable. On OUT_READY, go to IDLE.
- CORE_RST is 1 in every state except CLEAR and reset.
- Y_i is 0 outside FEED.
- X, M and mu hold their values from accept until the next accept.
- Inputs A, B, M_IN and MU_IN are ignored except on the accept edge.
- IN_VALID is ignored outside IDLE, with no queuing.
- The host may change inputs after the accept edge.

## Timing
- Reset (RST=0 at an edge) forces IDLE. Output values under reset:
  - IN_READY=0 during reset, then 1 on the first cycle after RST rises.
  - OUT_VALID=0, Z=0, CORE_RST=0, Y_i=0, X=0, M=0, mu=0.
- Reset mid-operation, in any state, aborts the operation; the partial result is discarded and never presented.
- Accept at edge t. CLEAR occupies the cycle t→t+1. FEED occupies edges t+2 … t+2+D.
- OUT_VALID rises after edge t+D+3 (without the macro). For n=8 and m=4 that is 5 cycles.
- An OUT_READY high in the first DONE cycle completes the transfer. IN_READY then rises the next cycle, giving a minimum throughput of one result every D+5 cycles.
- OUT_READY outside DONE has no effect.

## Configuration
- BARRETT_FINAL_SUB_EN defined: a CORRECT state is inserted between CAPTURE and DONE.
  - In CORRECT: Z ← (Z ≥ {1'b0,M}) ? Z − M : Z, a single conditional subtraction.
  - This guarantees Z < M and adds one cycle of latency (D+4).
- Not defined: Z is the raw Z_OUT and latency is D+3.

## Structure
- Shared package barrett_pkg holds:
  - the state enum: IDLE, CLEAR, FEED, CAPTURE, CORRECT, DONE;
  - the localparam D = n/m;
  - a function giving the mu width m+5.
- The digit counter width is $clog2(D+1).
- Elaboration-time check that n % m == 0.
- One natural sub-module: barrett_digit_sr, an n-bit load/shift-left-by-m register with top-digit output.
- The core itself is instantiated outside this block, in the integrating top or the bench.

## Test plan
- Reset: hold RST=0 for 3 cycles -> all outputs are 0. After release, IN_READY=1 with no spurious OUT_VALID.
- Basic, with n=8, m=4, A=200, B=150 (0x96), M=251 and matching mu:
  - Y_i sequence in FEED is 0, 9, 6.
  - CORE_RST is low exactly one cycle.
  - Z=131 with OUT_VALID 5 cycles after accept, or 6 cycles with BARRETT_FINAL_SUB_EN.
- Backpressure: hold OUT_READY=0 for 10 cycles -> Z stays stable, OUT_VALID stays high and IN_READY stays 0. Raising OUT_READY -> IN_READY=1 the next cycle.
- Back-to-back: feed the full vector file (A, B, M, mu, golden) with IN_VALID held high -> every Z equals golden, and the accept interval is D+5 cycles.
- Reset mid-FEED: RST=0 at FEED k=1 -> IDLE and no OUT_VALID. A new operation afterwards returns the correct Z.
- Final subtraction: with BARRETT_FINAL_SUB_EN, use a core stub forcing Z_OUT=M+5 -> Z=5. Without the macro -> Z=M+5.
